hack_dmux: RTL and testbench



---
 rtl/hack_dmux.sv | 66 ++++++
 tb/tb_hack_dmux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hack_dmux.sv
// Hack DMux primitive: combinational 1-to-2 routing plus a registered shadow
// stage with saturating per-channel activity counters.
module hack_dmux #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic in_nz;
    logic hit_a;
    logic hit_b;
    logic sat_a;
    logic sat_b;

    // Gate-level routing: the non-selected channel is forced to zero.
    always_comb begin
        a = '0;
        b = '0;
        if (sel) begin
            b = in;
        end else begin
            a = in;
        end
    end

    always_comb begin
        in_nz = (in != '0);
        hit_a = in_nz && !sel;
        hit_b = in_nz && sel;
        sat_a = (cnt_a == {CNT_W{1'b1}});
        sat_b = (cnt_b == {CNT_W{1'b1}});
    end

    // Shadow registers and saturating counters; at most one counter moves per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            sel_q <= sel;
            if (hit_a && !sat_a) begin
                cnt_a <= cnt_a + CNT_W'(1);
            end
            if (hit_b && !sat_b) begin
                cnt_b <= cnt_b + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hack_dmux.sv
// Scoreboard bench for hack_dmux: stimulus queues hand-computed expectations,
// a monitor process samples the DUTs and compares on each sample request.
module tb_hack_dmux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in1;
    logic       sel1;
    logic [3:0] in4;
    logic       sel4;

    logic       a1, b1, aq1, bq1, selq1;
    logic [7:0] ca1, cb1;
    logic [3:0] a4, b4, aq4, bq4;
    logic       selq4;
    logic [7:0] ca4, cb4;

    hack_dmux #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1),
        .a(a1), .b(b1), .a_q(aq1), .b_q(bq1), .sel_q(selq1),
        .cnt_a(ca1), .cnt_b(cb1)
    );

    hack_dmux #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4),
        .a(a4), .b(b4), .a_q(aq4), .b_q(bq4), .sel_q(selq4),
        .cnt_a(ca4), .cnt_b(cb4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample;
    int   asserts  = 0;
    int   failures = 0;

    localparam int A1 = 0, B1 = 1, AQ1 = 2, BQ1 = 3, SELQ1 = 4, CA1 = 5, CB1 = 6;
    localparam int A4 = 7, B4 = 8, AQ4 = 9, BQ4 = 10, SELQ4 = 11, CA4 = 12, CB4 = 13;

    function automatic logic [31:0] get_sig(input int id);
        case (id)
            A1:      return 32'(a1);
            B1:      return 32'(b1);
            AQ1:     return 32'(aq1);
            BQ1:     return 32'(bq1);
            SELQ1:   return 32'(selq1);
            CA1:     return 32'(ca1);
            CB1:     return 32'(cb1);
            A4:      return 32'(a4);
            B4:      return 32'(b4);
            AQ4:     return 32'(aq4);
            BQ4:     return 32'(bq4);
            SELQ4:   return 32'(selq4);
            CA4:     return 32'(ca4);
            CB4:     return 32'(cb4);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drains every queued expectation at each sample request.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = get_sig(e.sig);
                asserts++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input string name, input int sig, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Ask the monitor to sample now; a stalled monitor counts as a failure.
    task automatic check_now();
        int waited = 0;
        ->sample;
        while (sb.size() > 0 && waited < 10) begin
            #0.1;
            waited++;
        end
        if (sb.size() > 0) begin
            asserts++;
            failures++;
            $display("FAIL monitor_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic push_regs1(input string tag, input logic aq, input logic bq,
                              input logic sq, input logic [7:0] ca, input logic [7:0] cb);
        push({tag, "_a_q"},   AQ1,   32'(aq));
        push({tag, "_b_q"},   BQ1,   32'(bq));
        push({tag, "_sel_q"}, SELQ1, 32'(sq));
        push({tag, "_cnt_a"}, CA1,   32'(ca));
        push({tag, "_cnt_b"}, CB1,   32'(cb));
    endtask

    // Advance past one rising edge; sampling happens 2 time units after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Truth table rows: {in, sel, a, b}
    logic [3:0] tt [4];

    initial begin
        tt[0] = 4'b0000;
        tt[1] = 4'b0100;
        tt[2] = 4'b1010;
        tt[3] = 4'b1101;

        rst_n = 1'b0;
        in1 = 1'b1; sel1 = 1'b1;
        in4 = 4'h0; sel4 = 1'b0;

        // Reset held across clock edges with active inputs.
        step(3);
        push_regs1("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        push("reset_a", A1, 32'd0);
        push("reset_b", B1, 32'd1);
        check_now();

        // Combinational truth table, valid during reset.
        for (int i = 0; i < 4; i++) begin
            logic [3:0] row;
            row  = tt[i];
            in1  = row[3];
            sel1 = row[2];
            #1;
            push($sformatf("tt%0d_a", i), A1, 32'(row[1]));
            push($sformatf("tt%0d_b", i), B1, 32'(row[0]));
            check_now();
        end

        // Release reset mid-cycle with idle inputs.
        in1 = 1'b0; sel1 = 1'b0;
        rst_n = 1'b1;
        step(1);
        push_regs1("idle", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        check_now();

        // One-cycle latency on each channel.
        in1 = 1'b1; sel1 = 1'b0;
        step(1);
        push_regs1("lat_a", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        check_now();
        sel1 = 1'b1;
        step(1);
        push_regs1("lat_b", 1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
        check_now();

        // Zero input on either channel leaves both counters alone.
        in1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel1 = i[0];
            step(1);
        end
        push_regs1("hold", 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        check_now();

        // Saturation of cnt_b: 254 at the boundary, then pinned at 255.
        in1 = 1'b1; sel1 = 1'b1;
        step(253);
        push("sat_pre_cnt_b", CB1, 32'd254);
        check_now();
        step(47);
        push_regs1("sat", 1'b0, 1'b1, 1'b1, 8'd1, 8'd255);
        check_now();

        // Asynchronous reset between edges clears everything before the next edge.
        #1;
        rst_n = 1'b0;
        #1;
        push_regs1("async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        push("async_rst_b", B1, 32'd1);
        check_now();
        #1;
        rst_n = 1'b1;
        sel1  = 1'b0;
        step(1);
        push_regs1("restart", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        check_now();

        // Multi-bit routing on the WIDTH=4 instance.
        in4 = 4'b1010; sel4 = 1'b0;
        #1;
        push("w4_a_sel0", A4, 32'hA);
        push("w4_b_sel0", B4, 32'h0);
        check_now();
        step(1);
        push("w4_a_q", AQ4, 32'hA);
        push("w4_cnt_a", CA4, 32'd1);
        check_now();
        sel4 = 1'b1;
        #1;
        push("w4_a_sel1", A4, 32'h0);
        push("w4_b_sel1", B4, 32'hA);
        check_now();
        step(1);
        push("w4_b_q", BQ4, 32'hA);
        push("w4_sel_q", SELQ4, 32'd1);
        push("w4_cnt_b", CB4, 32'd1);
        check_now();
        in4 = 4'b0000;
        step(3);
        push("w4_zero_a_q", AQ4, 32'h0);
        push("w4_zero_b_q", BQ4, 32'h0);
        push("w4_zero_cnt_a", CA4, 32'd1);
        push("w4_zero_cnt_b", CB4, 32'd1);
        check_now();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
